// File: rtl/fp_unpack_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_unpack_pipe
// Description : Two-stage IEEE-754 to unsigned Q1.(FIX_W-1) unpacker with
//               rounding, saturation, class flags and valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unpack_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FIX_W = 32,
    parameter int ROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [FIX_W-1:0]       out_mag,
    output logic                   out_zero,
    output logic                   out_special,
    output logic                   out_ovf,
    output logic                   out_unf
);

    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int SH_MAX = FIX_W + MAN_W + 1;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int SIG_W  = MAN_W + 1;
    localparam int TW     = FIX_W + MAN_W;
    localparam int WW     = TW + 2;
    localparam int RS_W   = $clog2(SH_MAX + MAN_W + 1);

    localparam logic [EXP_W:0] BIAS_V = (EXP_W+1)'(BIAS);

    localparam logic [2:0] CLS_NORMAL  = 3'd0;
    localparam logic [2:0] CLS_ZERO    = 3'd1;
    localparam logic [2:0] CLS_SPECIAL = 3'd2;
    localparam logic [2:0] CLS_DENORM  = 3'd3;
    localparam logic [2:0] CLS_OVF     = 3'd4;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic s1_valid_q;
    logic out_valid_q;

    assign w_s2_adv = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || w_s2_adv;

    // ------------------------------------------------------------------
    // Stage 1: field split, classification and shift clamp
    // ------------------------------------------------------------------
    logic                 w_sign;
    logic [EXP_W-1:0]     w_exp;
    logic [MAN_W-1:0]     w_man;
    logic [EXP_W:0]       w_sh_full;

    logic [2:0]           s1_cls_d,  s1_cls_q;
    logic [SH_W-1:0]      s1_sh_d,   s1_sh_q;
    logic [SIG_W-1:0]     s1_sig_d,  s1_sig_q;
    logic                 s1_sign_q;

    assign w_sign    = in_data[EXP_W+MAN_W];
    assign w_exp     = in_data[EXP_W+MAN_W-1:MAN_W];
    assign w_man     = in_data[MAN_W-1:0];
    assign w_sh_full = BIAS_V - {1'b0, w_exp};
    assign s1_sig_d  = {1'b1, w_man};

    always_comb begin
        s1_sh_d = (32'(w_sh_full) > 32'(SH_MAX)) ? SH_W'(SH_MAX) : SH_W'(w_sh_full);
        if (w_exp == '0 && w_man == '0) begin
            s1_cls_d = CLS_ZERO;
        end else if (&w_exp) begin
            s1_cls_d = CLS_SPECIAL;
        end else if (w_exp == '0) begin
            s1_cls_d = CLS_DENORM;
        end else if (32'(w_exp) > 32'(BIAS)) begin
            s1_cls_d = CLS_OVF;
        end else begin
            s1_cls_d = CLS_NORMAL;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift, round, saturate
    // ------------------------------------------------------------------
    // w_t is S scaled by 2^(FIX_W-1); a further right shift of MAN_W+sh
    // yields the Q1.(FIX_W-1) magnitude. The appended LSB catches the
    // first dropped bit for rounding.
    logic [TW-1:0]        w_t;
    logic [RS_W-1:0]      w_rs;
    logic [WW-1:0]        w_wide;
    logic [FIX_W-1:0]     w_trunc;
    logic                 w_hi;
    logic                 w_inc;
    logic [FIX_W:0]       w_sum;
    logic                 w_sat;

    assign w_t     = {s1_sig_q, {(FIX_W-1){1'b0}}};
    assign w_rs    = RS_W'(s1_sh_q) + RS_W'(MAN_W);
    assign w_wide  = {1'b0, w_t, 1'b0} >> w_rs;
    assign w_trunc = w_wide[FIX_W:1];
    assign w_hi    = |w_wide[WW-1:FIX_W+1];
    assign w_inc   = (ROUND != 0) && w_wide[0];
    assign w_sum   = {1'b0, w_trunc} + {{FIX_W{1'b0}}, w_inc};
    assign w_sat   = w_hi || w_sum[FIX_W];

    logic                 out_sign_d,    out_sign_q;
    logic [FIX_W-1:0]     out_mag_d,     out_mag_q;
    logic                 out_zero_d,    out_zero_q;
    logic                 out_special_d, out_special_q;
    logic                 out_ovf_d,     out_ovf_q;
    logic                 out_unf_d,     out_unf_q;

    always_comb begin
        out_sign_d    = s1_sign_q;
        out_mag_d     = '0;
        out_zero_d    = 1'b0;
        out_special_d = 1'b0;
        out_ovf_d     = 1'b0;
        out_unf_d     = 1'b0;
        case (s1_cls_q)
            CLS_ZERO:    out_zero_d    = 1'b1;
            CLS_SPECIAL: out_special_d = 1'b1;
            CLS_DENORM:  out_unf_d     = 1'b1;
            CLS_OVF: begin
                out_mag_d = '1;
                out_ovf_d = 1'b1;
            end
            default: begin
                if (w_sat) begin
                    out_mag_d = '1;
                    out_ovf_d = 1'b1;
                end else begin
                    out_mag_d = w_sum[FIX_W-1:0];
                    out_unf_d = (w_sum[FIX_W-1:0] == '0);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_cls_q      <= CLS_ZERO;
            s1_sh_q       <= '0;
            s1_sig_q      <= '0;
            out_valid_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_mag_q     <= '0;
            out_zero_q    <= 1'b0;
            out_special_q <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_unf_q     <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign_q <= w_sign;
                s1_cls_q  <= s1_cls_d;
                s1_sh_q   <= s1_sh_d;
                s1_sig_q  <= s1_sig_d;
            end
            if (w_s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_sign_q    <= out_sign_d;
                    out_mag_q     <= out_mag_d;
                    out_zero_q    <= out_zero_d;
                    out_special_q <= out_special_d;
                    out_ovf_q     <= out_ovf_d;
                    out_unf_q     <= out_unf_d;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sign    = out_sign_q;
    assign out_mag     = out_mag_q;
    assign out_zero    = out_zero_q;
    assign out_special = out_special_q;
    assign out_ovf     = out_ovf_q;
    assign out_unf     = out_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_unpack_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fp_unpack_pipe
// Description : Directed-vector bench for fp_unpack_pipe (FP32 round/trunc
//               instances and an FP16 -> Q1.15 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_unpack_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // FP32, ROUND=1 (A) and ROUND=0 (B) share all inputs
    logic        a_in_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic        a_in_ready, a_out_valid, a_out_sign;
    logic [31:0] a_out_mag;
    logic        a_zero, a_special, a_ovf, a_unf;
    logic        b_in_ready, b_out_valid, b_out_sign;
    logic [31:0] b_out_mag;
    logic        b_zero, b_special, b_ovf, b_unf;

    // FP16 -> Q1.15
    logic        h_in_valid, h_out_ready;
    logic [15:0] h_in_data;
    logic        h_in_ready, h_out_valid, h_out_sign;
    logic [15:0] h_out_mag;
    logic        h_zero, h_special, h_ovf, h_unf;

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .FIX_W(32), .ROUND(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sign(a_out_sign), .out_mag(a_out_mag), .out_zero(a_zero),
        .out_special(a_special), .out_ovf(a_ovf), .out_unf(a_unf));

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .FIX_W(32), .ROUND(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_data(a_in_data), .out_valid(b_out_valid), .out_ready(a_out_ready),
        .out_sign(b_out_sign), .out_mag(b_out_mag), .out_zero(b_zero),
        .out_special(b_special), .out_ovf(b_ovf), .out_unf(b_unf));

    fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .FIX_W(16), .ROUND(1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_data(h_in_data), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_sign(h_out_sign), .out_mag(h_out_mag), .out_zero(h_zero),
        .out_special(h_special), .out_ovf(h_ovf), .out_unf(h_unf));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // flags packed as {zero, special, ovf, unf}
    task automatic a_op(input logic [31:0] d, input logic [31:0] emag,
                        input logic [3:0] eflags, input logic esign, input string tag);
        int cnt;
        @(negedge clk);
        a_out_ready = 1'b1;
        a_in_data   = d;
        a_in_valid  = 1'b1;
        cnt = 0;
        while (!a_in_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_valid"}, a_out_valid, 1);
        check_eq({tag, "_mag"},   a_out_mag, emag);
        check_eq({tag, "_flags"}, {a_zero, a_special, a_ovf, a_unf}, eflags);
        check_eq({tag, "_sign"},  a_out_sign, esign);
    endtask

    task automatic h_op(input logic [15:0] d, input logic [15:0] emag,
                        input logic [3:0] eflags, input string tag);
        int cnt;
        @(negedge clk);
        h_out_ready = 1'b1;
        h_in_data   = d;
        h_in_valid  = 1'b1;
        cnt = 0;
        while (!h_in_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        h_in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_valid"}, h_out_valid, 1);
        check_eq({tag, "_mag"},   h_out_mag, emag);
        check_eq({tag, "_flags"}, {h_zero, h_special, h_ovf, h_unf}, eflags);
        check_eq({tag, "_sign"},  h_out_sign, d[15]);
    endtask

    // Real-valued reference for the FP16 -> Q1.15 instance
    function automatic void model16(input logic [15:0] x, output logic [15:0] mag,
                                    output logic [3:0] fl);
        int  e;
        int  m;
        int  q;
        real v;
        e   = int'(x[14:10]);
        m   = int'(x[9:0]);
        mag = '0;
        fl  = 4'b0000;
        if (e == 0 && m == 0) begin
            fl = 4'b1000;
        end else if (e == 31) begin
            fl = 4'b0100;
        end else if (e == 0) begin
            fl = 4'b0001;
        end else if (e > 15) begin
            mag = 16'hFFFF;
            fl  = 4'b0010;
        end else begin
            v = real'(1024 + m) * 32.0;
            for (int k = e; k < 15; k++) v = v / 2.0;
            q = $rtoi(v);
            if (v - real'(q) >= 0.5) q++;
            if (q > 65535) begin
                mag = 16'hFFFF;
                fl  = 4'b0010;
            end else begin
                mag = q[15:0];
                if (q == 0) fl = 4'b0001;
            end
        end
    endfunction

    logic [31:0] s_in  [3] = '{32'h3F800000, 32'h3F000000, 32'hBFC00000};
    logic [31:0] s_exp [3] = '{32'h80000000, 32'h40000000, 32'hC0000000};
    logic        s_sgn [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] bp_in [3] = '{32'h3F800000, 32'h3F000000, 32'h3E800000};
    logic [31:0] bp_exp[3] = '{32'h80000000, 32'h40000000, 32'h20000000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic [15:0] hx, hmag;
        logic [3:0]  hfl;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_in_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_out_mag", a_out_mag, 0);
        check_eq("rst_flags", {a_out_sign, a_zero, a_special, a_ovf, a_unf}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", a_in_ready, 1);

        // Back-to-back stream, two-cycle latency, one result per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("stream_valid%0d", i), a_out_valid, (i >= 2 && i < 5));
            if (i >= 2 && i < 5) begin
                check_eq($sformatf("stream_mag%0d", i), a_out_mag, s_exp[i-2]);
                check_eq($sformatf("stream_sign%0d", i), a_out_sign, s_sgn[i-2]);
            end
            if (i < 3) begin
                a_in_valid = 1'b1;
                a_in_data  = s_in[i];
            end else begin
                a_in_valid = 1'b0;
            end
        end

        // Rounding, saturation, classes
        a_op(32'h30400000, 32'h00000002, 4'b0000, 1'b0, "rnd_up");
        check_eq("trunc_mag", b_out_mag, 32'h00000001);
        a_op(32'h2F800000, 32'h00000001, 4'b0000, 1'b0, "rnd_half");
        check_eq("trunc_half_mag", b_out_mag, 0);
        check_eq("trunc_half_unf", b_unf, 1);
        a_op(32'h30000000, 32'h00000001, 4'b0000, 1'b0, "lsb");
        a_op(32'h3FFFFFFF, 32'hFFFFFF00, 4'b0000, 1'b0, "max_norm");
        a_op(32'h3F7FFFFF, 32'h7FFFFF80, 4'b0000, 1'b0, "below_one");
        a_op(32'h40000000, 32'hFFFFFFFF, 4'b0010, 1'b0, "ovf");
        a_op(32'h7FC00000, 32'h00000000, 4'b0100, 1'b0, "nan");
        a_op(32'hFF800000, 32'h00000000, 4'b0100, 1'b1, "neg_inf");
        a_op(32'h80000000, 32'h00000000, 4'b1000, 1'b1, "neg_zero");
        a_op(32'h2B800000, 32'h00000000, 4'b0001, 1'b0, "tiny_unf");
        a_op(32'h00000001, 32'h00000000, 4'b0001, 1'b0, "denorm");

        // Backpressure: two held, third waits
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = bp_in[0];
        @(negedge clk);
        check_eq("bp_ready1", a_in_ready, 1);
        a_in_data = bp_in[1];
        @(negedge clk);
        check_eq("bp_full", a_in_ready, 0);
        check_eq("bp_valid", a_out_valid, 1);
        check_eq("bp_mag0", a_out_mag, bp_exp[0]);
        a_in_data = bp_in[2];
        held = a_out_mag;
        repeat (3) @(negedge clk);
        check_eq("bp_stable_mag", a_out_mag, held);
        check_eq("bp_stable_valid", a_out_valid, 1);
        check_eq("bp_still_full", a_in_ready, 0);
        a_out_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb", a_in_ready, 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_eq("bp_valid1", a_out_valid, 1);
        check_eq("bp_mag1", a_out_mag, bp_exp[1]);
        @(negedge clk);
        check_eq("bp_valid2", a_out_valid, 1);
        check_eq("bp_mag2", a_out_mag, bp_exp[2]);
        @(negedge clk);
        check_eq("bp_drained", a_out_valid, 0);

        // Asynchronous reset with two items in flight
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 32'hBF800000;
        @(negedge clk);
        a_in_data  = 32'h3F000000;
        @(negedge clk);
        a_in_valid = 1'b0;
        check_eq("inflight_valid", a_out_valid, 1);
        check_eq("inflight_sign", a_out_sign, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", a_out_valid, 0);
        check_eq("arst_mag", a_out_mag, 0);
        check_eq("arst_sign", a_out_sign, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", a_in_ready, 1);
        check_eq("rel_no_ghost0", a_out_valid, 0);
        @(negedge clk);
        check_eq("rel_no_ghost1", a_out_valid, 0);
        a_op(32'h3F800000, 32'h80000000, 4'b0000, 1'b0, "post_rst");

        // FP16 -> Q1.15
        h_op(16'h3C00, 16'h8000, 4'b0000, "h_one");
        h_op(16'h4000, 16'hFFFF, 4'b0010, "h_ovf");
        h_op(16'h3800, 16'h4000, 4'b0000, "h_half");
        h_op(16'h0001, 16'h0000, 4'b0001, "h_denorm");
        for (int i = 0; i < 24; i++) begin
            hx = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 18)), 10'($urandom)};
            model16(hx, hmag, hfl);
            h_op(hx, hmag, hfl, $sformatf("h_rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
